avg_interp: RTL

AVG_INTERP -- requirements
Module: avg_interp

---
 rtl/avg_interp.sv | 114 +++++++++++
 1 files changed

// File: rtl/avg_interp.sv
// Linear interpolator: for every accepted sample after the first, emit R = 2^LOG2_R
// points stepping from the previous sample towards the newest one.
module avg_interp #(
    parameter int WIDTH  = 16,
    parameter int LOG2_R = 3
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [LOG2_R-1:0] K_LAST = '1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_cur;
    logic [WIDTH-1:0]    r_prev;
    logic [WIDTH-1:0]    w_cur_next;
    logic [WIDTH-1:0]    w_prev_next;
    logic [LOG2_R-1:0]   r_k;
    logic [LOG2_R-1:0]   w_k_next;
    logic                w_ready;
    logic                w_valid;

    logic signed [WIDTH:0]        w_diff;
    logic signed [WIDTH+LOG2_R:0] w_diff_ext;
    logic signed [WIDTH+LOG2_R:0] w_k_ext;
    logic signed [WIDTH+LOG2_R:0] w_prod;
    logic [WIDTH-1:0]             w_step;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_cur   <= '0;
            r_prev  <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_next;
            r_cur   <= w_cur_next;
            r_prev  <= w_prev_next;
            r_k     <= w_k_next;
        end
    end

    // A new sample enters EMIT only on the final phase's transfer, so the
    // output stream continues without a bubble.
    always_comb begin
        w_state_next = r_state;
        w_cur_next   = r_cur;
        w_prev_next  = r_prev;
        w_k_next     = r_k;
        w_ready      = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_cur_next   = in_data;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_prev_next  = r_cur;
                    w_cur_next   = in_data;
                    w_k_next     = '0;
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                w_valid = 1'b1;
                w_ready = (r_k == K_LAST) && out_ready;
                if (out_ready) begin
                    if (r_k != K_LAST) begin
                        w_k_next = r_k + 1'b1;
                    end else if (in_valid) begin
                        w_prev_next = r_cur;
                        w_cur_next  = in_data;
                        w_k_next    = '0;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    // prev + floor(k*(cur-prev)/R); the result stays between prev and cur, so truncation is exact.
    assign w_diff     = $signed({1'b0, r_cur}) - $signed({1'b0, r_prev});
    assign w_diff_ext = {{LOG2_R{w_diff[WIDTH]}}, w_diff};
    assign w_k_ext    = {{(WIDTH + 1){1'b0}}, r_k};
    assign w_prod     = w_k_ext * w_diff_ext;
    assign w_step     = WIDTH'(w_prod >>> LOG2_R);

    assign out_data  = r_prev + w_step;
    assign out_valid = w_valid;
    assign in_ready  = w_ready && !rst;

endmodule
